// File: rtl/hd44780_nybble_receiver.sv
// hd44780_nybble_receiver: LCD-side HD44780 bus sampler that reassembles bytes and flags E timing violations.
module hd44780_nybble_receiver #(
  parameter int PWEH_MIN = 22,
  parameter int TCYCE_MIN = 48,
  parameter int COUNT_BITS = 8
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       i_rs,
  input  logic       i_e,
  input  logic [3:0] i_nybble,
  output logic [7:0] o_byte,
  output logic       o_rs,
  output logic       o_stb,
  output logic       o_mode_4bit,
  output logic       o_err_pweh,
  output logic       o_err_tcyc,
  output logic       o_err_rs
);
  localparam logic [0:0] MODE8 = 1'b0;
  localparam logic [0:0] MODE4 = 1'b1;
  localparam logic [COUNT_BITS-1:0] CMAX = '1;
  localparam logic [COUNT_BITS:0] PWEH_L = (COUNT_BITS+1)'(PWEH_MIN);
  localparam logic [COUNT_BITS-1:0] TCYCE_L = COUNT_BITS'(TCYCE_MIN);
  logic [5:0] s1, s2, s3;
  logic [0:0] state;
  logic phase_high, seen_rise, hi_rs;
  logic [3:0] hi;
  logic [COUNT_BITS-1:0] hcnt, pcnt;
  logic rise, fall, rs_s;
  logic [3:0] nyb;
  logic [COUNT_BITS:0] hcnt_inc;
  // pipe word is {rs, e, nybble}; data comes from s3, the last sample taken with E high
  assign rise = s2[4] & ~s3[4];
  assign fall = ~s2[4] & s3[4];
  assign rs_s = s3[5];
  assign nyb = s3[3:0];
  assign hcnt_inc = {1'b0, hcnt} + 1'b1;
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      {s1, s2, s3} <= '0;
      state <= MODE8;
      phase_high <= 1'b1;
      seen_rise <= 1'b0;
      hi <= '0;
      hi_rs <= 1'b0;
      hcnt <= '0;
      pcnt <= '0;
      o_byte <= '0;
      o_rs <= 1'b0;
      o_stb <= 1'b0;
      o_mode_4bit <= 1'b0;
      o_err_pweh <= 1'b0;
      o_err_tcyc <= 1'b0;
      o_err_rs <= 1'b0;
    end else begin
      s1 <= {i_rs, i_e, i_nybble};
      s2 <= s1;
      s3 <= s2;
      o_stb <= 1'b0;
      o_err_pweh <= 1'b0;
      o_err_rs <= 1'b0;
      o_err_tcyc <= rise & seen_rise & (pcnt < TCYCE_L);
      seen_rise <= seen_rise | rise;
      pcnt <= rise ? '0 : (pcnt == CMAX) ? pcnt : pcnt + 1'b1;
      hcnt <= rise ? '0 : (s2[4] && hcnt != CMAX) ? hcnt + 1'b1 : hcnt;
      o_mode_4bit <= state;
      if (fall) begin
        o_err_pweh <= hcnt_inc < PWEH_L;
        if (state == MODE8) begin
          o_byte <= {nyb, 4'h0};
          o_rs <= rs_s;
          o_stb <= 1'b1;
          if (!rs_s && nyb == 4'b0010) begin
            state <= MODE4;
            phase_high <= 1'b1;
          end
        end else if (phase_high) begin
          hi <= nyb;
          hi_rs <= rs_s;
          phase_high <= 1'b0;
        end else begin
          o_byte <= {hi, nyb};
          o_rs <= hi_rs;
          o_stb <= 1'b1;
          o_err_rs <= hi_rs != rs_s;
          phase_high <= 1'b1;
          if (!hi_rs && hi == 4'b0011) state <= MODE8;
        end
      end
    end
  end
endmodule

// File: tb/tb_hd44780_nybble_receiver.sv
// tb_hd44780_nybble_receiver: directed HD44780 bus stimulus with a strobe scoreboard.
module tb_hd44780_nybble_receiver;
  logic CLK_I, RST_I, i_rs, i_e;
  logic [3:0] i_nybble;
  logic [7:0] o_byte;
  logic o_rs, o_stb, o_mode_4bit, o_err_pweh, o_err_tcyc, o_err_rs;
  typedef struct {
    logic [7:0] b;
    logic rs, pw, er, m;
    int c;
  } exp_t;
  exp_t q[$];
  int checks = 0, failures = 0, cyc = 0;
  int n_stb = 0, n_pweh = 0, n_tcyc = 0, n_rs = 0;
  logic mode_chk = 1'b0, mode_exp = 1'b0;
  hd44780_nybble_receiver dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .i_rs(i_rs), .i_e(i_e), .i_nybble(i_nybble),
    .o_byte(o_byte), .o_rs(o_rs), .o_stb(o_stb), .o_mode_4bit(o_mode_4bit),
    .o_err_pweh(o_err_pweh), .o_err_tcyc(o_err_tcyc), .o_err_rs(o_err_rs)
  );
  initial begin
    CLK_I = 1'b0;
    forever #5 CLK_I = ~CLK_I;
  end
  always @(posedge CLK_I) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  always @(negedge CLK_I) begin
    exp_t e;
    if (mode_chk) begin
      chk("mode_after_stb", 32'(o_mode_4bit), 32'(mode_exp));
      mode_chk = 1'b0;
    end
    if (o_err_pweh) n_pweh++;
    if (o_err_tcyc) n_tcyc++;
    if (o_err_rs) n_rs++;
    if (o_stb) begin
      n_stb++;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("stb_cycle", cyc, e.c);
        chk("byte", 32'(o_byte), 32'(e.b));
        chk("rs", 32'(o_rs), 32'(e.rs));
        chk("err_pweh_with_stb", 32'(o_err_pweh), 32'(e.pw));
        chk("err_rs_with_stb", 32'(o_err_rs), 32'(e.er));
        mode_exp = e.m;
        mode_chk = 1'b1;
      end else chk("spurious_stb", 32'(o_stb), 0);
    end
  end
  task automatic send(input logic rs, input logic [3:0] n, input int hi, input int lo,
                      input logic stb, input logic [7:0] b, input logic ers,
                      input logic pw, input logic erl, input logic m);
    @(negedge CLK_I);
    i_rs = rs;
    i_nybble = n;
    i_e = 1'b1;
    repeat (hi) @(negedge CLK_I);
    i_e = 1'b0;
    if (stb) q.push_back('{b: b, rs: ers, pw: pw, er: erl, m: m, c: cyc + 3});
    repeat (lo - 1) @(negedge CLK_I);
  endtask
  initial begin
    RST_I = 1'b1;
    i_rs = 1'b0;
    i_e = 1'b0;
    i_nybble = 4'h0;
    @(negedge CLK_I);
    i_e = 1'b1;
    chk("rst_outputs_a", {o_byte, o_rs, o_stb, o_mode_4bit, o_err_pweh, o_err_tcyc, o_err_rs}, 0);
    @(negedge CLK_I);
    i_e = 1'b0;
    chk("rst_outputs_b", {o_byte, o_rs, o_stb, o_mode_4bit, o_err_pweh, o_err_tcyc, o_err_rs}, 0);
    RST_I = 1'b0;
    @(negedge CLK_I);
    chk("post_rst_outputs", {o_byte, o_rs, o_stb, o_mode_4bit, o_err_pweh, o_err_tcyc, o_err_rs}, 0);
    repeat (3) send(1'b0, 4'h3, 30, 170, 1'b1, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("stb_count_8bit", n_stb, 3);
    chk("err_count_8bit", n_pweh + n_tcyc + n_rs, 0);
    send(1'b0, 4'h2, 30, 170, 1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 1'b1);
    send(1'b1, 4'h4, 30, 170, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("no_stb_high_half", n_stb, 4);
    send(1'b1, 4'h1, 30, 170, 1'b1, 8'h41, 1'b1, 1'b0, 1'b0, 1'b1);
    send(1'b1, 4'h4, 30, 170, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    send(1'b1, 4'h2, 5, 195, 1'b1, 8'h42, 1'b1, 1'b1, 1'b0, 1'b1);
    send(1'b1, 4'h4, 22, 178, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    send(1'b1, 4'h3, 22, 178, 1'b1, 8'h43, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("pweh_count", n_pweh, 1);
    send(1'b1, 4'h4, 10, 10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    send(1'b1, 4'h5, 30, 170, 1'b1, 8'h45, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("tcyc_count", n_tcyc, 1);
    chk("pweh_count_2", n_pweh, 2);
    send(1'b1, 4'hA, 30, 170, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    send(1'b0, 4'h5, 30, 170, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("err_rs_count", n_rs, 1);
    send(1'b1, 4'hA, 30, 170, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    RST_I = 1'b1;
    repeat (2) @(negedge CLK_I);
    RST_I = 1'b0;
    chk("mode_after_mid_rst", 32'(o_mode_4bit), 0);
    send(1'b0, 4'h3, 30, 170, 1'b1, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
    send(1'b0, 4'h2, 30, 170, 1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 1'b1);
    send(1'b0, 4'h3, 30, 170, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    send(1'b0, 4'h8, 30, 170, 1'b1, 8'h38, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (5) @(negedge CLK_I);
    chk("scoreboard_drained", q.size(), 0);
    chk("stb_total", n_stb, 12);
    chk("pweh_total", n_pweh, 2);
    chk("tcyc_total", n_tcyc, 1);
    chk("err_rs_total", n_rs, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
